// File: rtl/herloa_pkg.sv
// Shared definitions for the HERLOA approximate adder pipeline:
// mode encoding, minimum approximate width and a saturating accumulate helper.
package herloa_pkg;

    localparam logic MODE_APPROX      = 1'b0;
    localparam logic MODE_EXACT       = 1'b1;
    localparam int   HERLOA_MIN_INACC = 4;

    // Adds inc to acc and clamps the result at max; callers narrow to counter width.
    function automatic logic [63:0] sat_add(
        input logic [63:0] acc,
        input logic [63:0] inc,
        input logic [63:0] max
    );
        logic [64:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum > {1'b0, max}) begin
            return max;
        end else begin
            return sum[63:0];
        end
    endfunction

endpackage

// File: rtl/herloa_lower.sv
// Combinational HERLOA lower part: K approximate sum bits plus the carry
// handed to the exact upper adder.
module herloa_lower #(
    parameter int K = 12
) (
    input  logic [K-1:0] i_a,
    input  logic [K-1:0] i_b,
    output logic [K-1:0] o_sum,
    output logic         o_cin
);

    logic w_n1;
    logic w_n2;
    logic w_n3;

    // Top four bits follow the HERLOA rules; everything below them is forced high.
    always_comb begin
        w_n1  = i_a[K-1] ^ i_b[K-1];
        w_n2  = i_a[K-2] & i_b[K-2];
        w_n3  = w_n1 & w_n2;
        o_sum = {K{1'b1}};
        o_sum[K-4] = w_n3 | i_a[K-4] | i_b[K-4];
        o_sum[K-3] = w_n3 | i_a[K-3] | i_b[K-3];
        o_sum[K-2] = (i_a[K-2] | i_b[K-2]) & ~(~w_n1 & w_n2);
        o_sum[K-1] = w_n1 | w_n2;
    end

    assign o_cin = i_a[K-1] & i_b[K-1];

    // Operand bits below K-4 never influence the approximation.
    if (K > 4) begin : g_low_ignored
        logic w_unused;
        assign w_unused = ^{i_a[K-5:0], i_b[K-5:0]};
    end

endmodule

// File: rtl/herloa_adder_pipe.sv
// Two-stage HERLOA approximate adder with per-beat exact/approximate select and
// valid/ready handshake. Error statistics are built only with HERLOA_ERRSTAT_EN.
module herloa_adder_pipe
    import herloa_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int INACC = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] err_mag
);

    localparam int K = INACC;
    localparam int U = WIDTH - INACC;

    if (INACC < HERLOA_MIN_INACC || INACC > WIDTH - 1) begin : g_bad_inacc
        $error("herloa_adder_pipe: INACC=%0d outside [4, WIDTH-1]", INACC);
    end

    logic [K-1:0] w_lo_apx;
    logic         w_cin_apx;
    logic [K:0]   w_lo_ex_full;
    logic [K-1:0] w_lo_sel;
    logic         w_cin_sel;
    logic         w_s1_load;
    logic         w_s2_load;
    logic [U:0]   w_up;
    logic [WIDTH:0] w_sum;

    logic             r_s1v;
    logic [K-1:0]     r_s1_lo;
    logic             r_s1_cin;
    logic [U-1:0]     r_s1_ua;
    logic [U-1:0]     r_s1_ub;
    logic             r_s2v;
    logic [WIDTH:0]   r_out_sum;

    herloa_lower #(.K(K)) u_lower (
        .i_a   (in_a[K-1:0]),
        .i_b   (in_b[K-1:0]),
        .o_sum (w_lo_apx),
        .o_cin (w_cin_apx)
    );

    assign w_lo_ex_full = {1'b0, in_a[K-1:0]} + {1'b0, in_b[K-1:0]};

    // Exact beats take the true lower sum and its carry; the upper add is shared.
    always_comb begin
        if (in_exact == MODE_EXACT) begin
            w_lo_sel  = w_lo_ex_full[K-1:0];
            w_cin_sel = w_lo_ex_full[K];
        end else begin
            w_lo_sel  = w_lo_apx;
            w_cin_sel = w_cin_apx;
        end
    end

    assign w_s2_load = ~r_s2v | out_ready;
    assign w_s1_load = ~r_s1v | w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_s2v;
    assign out_sum   = r_out_sum;

    assign w_up  = {1'b0, r_s1_ua} + {1'b0, r_s1_ub} + {{U{1'b0}}, r_s1_cin};
    assign w_sum = {w_up, r_s1_lo};

`ifdef HERLOA_ERRSTAT_EN
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic             r_s1_mode;
    logic [K-1:0]     r_s1_lo_ex;
    logic             r_s1_cin_ex;
    logic             r_s2_mode;
    logic [WIDTH:0]   r_s2_diff;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_err_mag;
    logic [U:0]       w_up_ex;
    logic [WIDTH:0]   w_sum_ex;
    logic [WIDTH:0]   w_diff;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_mag_next;
    logic             w_count;

    assign w_up_ex  = {1'b0, r_s1_ua} + {1'b0, r_s1_ub} + {{U{1'b0}}, r_s1_cin_ex};
    assign w_sum_ex = {w_up_ex, r_s1_lo_ex};

    // Absolute distance between the delivered result and the true sum.
    always_comb begin
        if (w_sum >= w_sum_ex) begin
            w_diff = w_sum - w_sum_ex;
        end else begin
            w_diff = w_sum_ex - w_sum;
        end
        w_cnt_next = CNT_W'(sat_add(64'(r_err_cnt), 64'd1, CNT_MAX));
        w_mag_next = CNT_W'(sat_add(64'(r_err_mag), 64'(r_s2_diff), CNT_MAX));
    end

    assign w_count = r_s2v & out_ready & (r_s2_mode == MODE_APPROX) & (r_s2_diff != {(WIDTH+1){1'b0}});

    // Stage-1 side data needed only to reconstruct the exact sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_mode   <= MODE_APPROX;
            r_s1_lo_ex  <= {K{1'b0}};
            r_s1_cin_ex <= 1'b0;
        end else if (w_s1_load && in_valid) begin
            r_s1_mode   <= in_exact;
            r_s1_lo_ex  <= w_lo_ex_full[K-1:0];
            r_s1_cin_ex <= w_lo_ex_full[K];
        end
    end

    // Stage-2 side data travelling with each result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_mode <= MODE_APPROX;
            r_s2_diff <= {(WIDTH+1){1'b0}};
        end else if (w_s2_load && r_s1v) begin
            r_s2_mode <= r_s1_mode;
            r_s2_diff <= w_diff;
        end
    end

    // Statistics counters; a clear wins over a same-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= {CNT_W{1'b0}};
            r_err_mag <= {CNT_W{1'b0}};
        end else if (stat_clr) begin
            r_err_cnt <= {CNT_W{1'b0}};
            r_err_mag <= {CNT_W{1'b0}};
        end else if (w_count) begin
            r_err_cnt <= w_cnt_next;
            r_err_mag <= w_mag_next;
        end
    end

    assign err_cnt = r_err_cnt;
    assign err_mag = r_err_mag;
`else
    logic w_unused;
    assign w_unused = stat_clr;
    assign err_cnt  = {CNT_W{1'b0}};
    assign err_mag  = {CNT_W{1'b0}};
`endif

    // Stage 1: lower result bits, carry and upper operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1v    <= 1'b0;
            r_s1_lo  <= {K{1'b0}};
            r_s1_cin <= 1'b0;
            r_s1_ua  <= {U{1'b0}};
            r_s1_ub  <= {U{1'b0}};
        end else if (w_s1_load) begin
            r_s1v <= in_valid;
            if (in_valid) begin
                r_s1_lo  <= w_lo_sel;
                r_s1_cin <= w_cin_sel;
                r_s1_ua  <= in_a[WIDTH-1:K];
                r_s1_ub  <= in_b[WIDTH-1:K];
            end
        end
    end

    // Stage 2: upper add and the registered result, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2v     <= 1'b0;
            r_out_sum <= {(WIDTH+1){1'b0}};
        end else if (w_s2_load) begin
            r_s2v <= r_s1v;
            if (r_s1v) begin
                r_out_sum <= w_sum;
            end
        end
    end

endmodule

// File: tb/tb_herloa_adder_pipe.sv
// Self-checking bench for herloa_adder_pipe (WIDTH=15, INACC=12); works with or
// without HERLOA_ERRSTAT_EN.
module tb_herloa_adder_pipe;

    localparam int W  = 15;
    localparam int K  = 12;
    localparam int CW = 16;
    localparam int CMAX = 65535;
`ifdef HERLOA_ERRSTAT_EN
    localparam bit ERRSTAT = 1'b1;
`else
    localparam bit ERRSTAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, in_exact, out_valid, out_ready, stat_clr;
    logic [W-1:0]  in_a, in_b;
    logic [W:0]    out_sum;
    logic [CW-1:0] err_cnt, err_mag;

    int total = 0;
    int bad   = 0;
    int m_cnt = 0;
    int m_mag = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ex;
        logic [W:0]   sum;
        int           diff;
    } vec_t;

    typedef struct {
        logic [W:0] sum;
        int         diff;
        logic       ex;
    } exp_t;

    vec_t vecs[8];

    herloa_adder_pipe #(.WIDTH(W), .INACC(K), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .stat_clr(stat_clr),
        .err_cnt(err_cnt), .err_mag(err_mag)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W:0] ref_exact(input logic [W-1:0] a, input logic [W-1:0] b);
        return (W+1)'(int'(a) + int'(b));
    endfunction

    function automatic logic [W:0] ref_approx(input logic [W-1:0] a, input logic [W-1:0] b);
        int lo, up;
        bit n1, n2, n3;
        n1 = a[K-1] ^ b[K-1];
        n2 = a[K-2] & b[K-2];
        n3 = n1 & n2;
        lo = (1 << (K-4)) - 1;
        if (n3 | a[K-4] | b[K-4])            lo += 1 << (K-4);
        if (n3 | a[K-3] | b[K-3])            lo += 1 << (K-3);
        if ((a[K-2] | b[K-2]) & !(!n1 && n2)) lo += 1 << (K-2);
        if (n1 | n2)                          lo += 1 << (K-1);
        up = int'(a >> K) + int'(b >> K) + int'(a[K-1] & b[K-1]);
        return (W+1)'((up << K) + lo);
    endfunction

    function automatic int absdiff(input logic [W:0] x, input logic [W:0] y);
        return (x > y) ? int'(x) - int'(y) : int'(y) - int'(x);
    endfunction

    task automatic model_stat(input logic ex, input int d);
        if (!ex && d != 0) begin
            m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            m_mag = (m_mag + d > CMAX) ? CMAX : m_mag + d;
        end
    endtask

    task automatic check_stats(input string nm);
        check({nm, " err_cnt"}, err_cnt, ERRSTAT ? m_cnt : 0);
        check({nm, " err_mag"}, err_mag, ERRSTAT ? m_mag : 0);
    endtask

    // One isolated beat: checks two-cycle latency, result and counters after delivery.
    task automatic send_one(input vec_t v, input string nm);
        int lat;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_exact = v.ex; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, lat, 2);
        check({nm, " sum"}, out_sum, v.sum);
        model_stat(v.ex, v.diff);
        @(posedge clk); #1;
        check({nm, " drained"}, out_valid, 0);
        check_stats(nm);
    endtask

    // Streaming run against a scoreboard; rnd=0 gives back-to-back beats with a 3-cycle stall.
    task automatic stream(input int nbeats, input bit rnd, input string nm);
        exp_t q[$];
        exp_t e;
        int sent, got, cyc;
        bit hold, acc, saw_block;
        logic [W:0] hold_sum;
        logic [W:0] ap, ex;
        sent = 0; got = 0; cyc = 0; hold = 0; acc = 0; saw_block = 0; hold_sum = '0;
        while (got < nbeats && cyc < nbeats * 30 + 100) begin
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            acc = 0;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 3 && cyc <= 5);
            if (!in_valid && sent < nbeats && (!rnd || $urandom_range(0, 4) != 0)) begin
                in_a = W'($urandom); in_b = W'($urandom); in_exact = 1'($urandom);
                in_valid = 1'b1;
            end
            #1;
            if (hold) begin
                check({nm, " held valid"}, out_valid, 1);
                check({nm, " held sum"}, out_sum, hold_sum);
            end
            check({nm, " in_ready"}, in_ready, (q.size() < 2) || out_ready);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({nm, " spurious beat"}, 1, 0);
                end else begin
                    e = q.pop_front();
                    check({nm, " sum"}, out_sum, e.sum);
                    model_stat(e.ex, e.diff);
                    got++;
                end
            end
            hold = out_valid && !out_ready;
            hold_sum = out_sum;
            if (in_valid && !in_ready) saw_block = 1;
            if (in_valid && in_ready) begin
                ap = ref_approx(in_a, in_b);
                ex = ref_exact(in_a, in_b);
                e.sum  = in_exact ? ex : ap;
                e.diff = absdiff(ap, ex);
                e.ex   = in_exact;
                q.push_back(e);
                sent++;
                acc = 1;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check({nm, " delivered"}, got, nbeats);
        check_stats(nm);
        if (!rnd) check({nm, " in_ready dropped"}, saw_block, 1);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{15'h0000, 15'h0000, 1'b0, 16'h00FF, 255};
        vecs[1] = '{15'h0000, 15'h0000, 1'b1, 16'h0000, 0};
        vecs[2] = '{15'h0800, 15'h0800, 1'b0, 16'h10FF, 255};
        vecs[3] = '{15'h0800, 15'h0800, 1'b1, 16'h1000, 0};
        vecs[4] = '{15'h7FFF, 15'h7FFF, 1'b0, 16'hFBFF, 1023};
        vecs[5] = '{15'h7FFF, 15'h7FFF, 1'b1, 16'hFFFE, 0};
        vecs[6] = '{15'h0C00, 15'h0400, 1'b0, 16'h0FFF, 1};
        vecs[7] = '{15'h7000, 15'h1000, 1'b0, 16'h80FF, 255};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0;
        out_ready = 1'b1; stat_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_sum", out_sum, 0);
        check_stats("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send_one(vecs[i], $sformatf("vec%0d", i));
        end

        stream(10, 1'b0, "b2b stall");
        stream(300, 1'b1, "random");

        // Reset with two beats stalled in the pipe.
        @(negedge clk);
        out_ready = 1'b0; in_a = 15'h0123; in_b = 15'h0456; in_exact = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 15'h0789;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre-reset out_valid", out_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset in_ready", in_ready, 1);
        check("midreset out_sum", out_sum, 0);
        m_cnt = 0; m_mag = 0;
        check_stats("midreset");
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        send_one(vecs[0], "post-reset");

        // Statistics clear coinciding with a delivery.
        @(negedge clk);
        in_a = 15'h0000; in_b = 15'h0000; in_exact = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr beat valid", out_valid, 1);
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        m_cnt = 0; m_mag = 0;
        check("clr beat gone", out_valid, 0);
        check_stats("stat_clr");
        send_one(vecs[4], "after clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
